// File: rtl/psram_responder.sv
// Device-side octal PSRAM model: decodes SDR command/address/data frames on an
// oversampled sclk and answers reads and writes from an internal byte RAM.
module psram_responder #(
  parameter int          ADDR_BITS = 16,
  parameter int          LATENCY   = 4,
  parameter logic [7:0]  CMD_READ  = 8'h03,
  parameter logic [7:0]  CMD_WRITE = 8'h02
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       psram_cs_n,
  input  logic       psram_sclk,
  input  logic [7:0] psram_data_in,
  output logic [7:0] psram_data_out,
  output logic       psram_data_oe,
  output logic       active,
  output logic       cmd_error
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, WDATA, RDATA, IGNORE} state_t;

  state_t               state;
  logic                 sclk_q1, sclk_q2;
  logic                 cs_n_q1;
  logic [7:0]           data_q1;
  logic                 rise, fall;
  logic                 wr_en;
  logic                 op_write;
  logic [1:0]           byte_cnt;
  logic [3:0]           dummy_cnt;
  logic [ADDR_BITS-1:0] addr;
  logic [7:0]           mem [2**ADDR_BITS];

  // Only sclk needs the second stage for edge detection; cs_n and data are
  // consumed straight from the first stage.
  always_ff @(posedge clk) begin
    sclk_q1 <= psram_sclk;
    sclk_q2 <= sclk_q1;
    cs_n_q1 <= psram_cs_n;
    data_q1 <= psram_data_in;
  end

  assign rise   = sclk_q1 & ~sclk_q2;
  assign fall   = ~sclk_q1 & sclk_q2;
  assign active = (state != IDLE);
  assign wr_en  = !reset && !cs_n_q1 && (state == WDATA) && rise;

  always_ff @(posedge clk) begin
    if (wr_en) mem[addr] <= data_q1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      addr           <= '0;
      byte_cnt       <= '0;
      dummy_cnt      <= '0;
      op_write       <= 1'b0;
      psram_data_out <= '0;
      psram_data_oe  <= 1'b0;
      cmd_error      <= 1'b0;
    end else begin
      cmd_error <= 1'b0;
      if (cs_n_q1) begin
        state         <= IDLE;
        psram_data_oe <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= CMD;
          CMD: begin
            if (rise) begin
              if (data_q1 == CMD_READ || data_q1 == CMD_WRITE) begin
                op_write <= (data_q1 == CMD_WRITE);
                byte_cnt <= '0;
                state    <= ADDR;
              end else begin
                cmd_error <= 1'b1;
                state     <= IGNORE;
              end
            end
          end
          ADDR: begin
            if (rise) begin
              // Truncation keeps only the low ADDR_BITS of the 24-bit address.
              addr     <= ADDR_BITS'({addr, data_q1});
              byte_cnt <= byte_cnt + 2'd1;
              if (byte_cnt == 2'd2) begin
                if (op_write)          state <= WDATA;
                else if (LATENCY > 0) begin
                  dummy_cnt <= '0;
                  state     <= DUMMY;
                end else               state <= RDATA;
              end
            end
          end
          DUMMY: begin
            if (rise) begin
              dummy_cnt <= dummy_cnt + 4'd1;
              if ((dummy_cnt + 4'd1) == 4'(LATENCY)) state <= RDATA;
            end
          end
          WDATA: begin
            if (rise) addr <= addr + ADDR_BITS'(1);
          end
          RDATA: begin
            if (fall) begin
              psram_data_out <= mem[addr];
              psram_data_oe  <= 1'b1;
            end
            if (rise) addr <= addr + ADDR_BITS'(1);
          end
          IGNORE: state <= IGNORE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_psram_responder.sv
// Scoreboard bench for psram_responder: two instances (LATENCY 4 and 0) share
// sclk/data, each with its own chip select; reads are checked at sclk rise.
module tb_psram_responder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sclk = 1'b1;
  logic [7:0] din = '0;
  logic       cs0 = 1'b1, cs1 = 1'b1;
  logic [7:0] dout0, dout1;
  logic       oe0, oe1, act0, act1, err0, err1;

  int n_checks = 0;
  int n_fail   = 0;
  int err_cnt0 = 0;
  int err_cnt1 = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];

  always #5 clk = ~clk;

  psram_responder #(.ADDR_BITS(16), .LATENCY(4)) u0 (
    .clk(clk), .reset(reset), .psram_cs_n(cs0), .psram_sclk(sclk),
    .psram_data_in(din), .psram_data_out(dout0), .psram_data_oe(oe0),
    .active(act0), .cmd_error(err0));

  psram_responder #(.ADDR_BITS(16), .LATENCY(0)) u1 (
    .clk(clk), .reset(reset), .psram_cs_n(cs1), .psram_sclk(sclk),
    .psram_data_in(din), .psram_data_out(dout1), .psram_data_oe(oe1),
    .active(act1), .cmd_error(err1));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (err0 === 1'b1) err_cnt0++;
    if (err1 === 1'b1) err_cnt1++;
  end

  // Monitor: the controller samples read data on sclk rise while oe is high.
  always @(posedge sclk) begin
    if (oe0 === 1'b1) begin
      if (q0.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL rd0_unexpected: got %0h expected none", dout0);
      end else check("rd0", {24'h0, dout0}, {24'h0, q0.pop_front()});
    end
    if (oe1 === 1'b1) begin
      if (q1.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL rd1_unexpected: got %0h expected none", dout1);
      end else check("rd1", {24'h0, dout1}, {24'h0, q1.pop_front()});
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clock_byte(input logic [7:0] b);
    sclk = 1'b0; din = b; tick(4);
    sclk = 1'b1; tick(4);
  endtask

  task automatic start(input int sel);
    if (sel == 0) cs0 = 1'b0; else cs1 = 1'b0;
    tick(2);
  endtask

  task automatic stop();
    cs0 = 1'b1; cs1 = 1'b1; tick(4);
  endtask

  task automatic hdr(input logic [7:0] cmd, input logic [23:0] a);
    clock_byte(cmd);
    clock_byte(a[23:16]);
    clock_byte(a[15:8]);
    clock_byte(a[7:0]);
  endtask

  task automatic wr(input int sel, input logic [23:0] a, input int n, input logic [31:0] d);
    start(sel);
    hdr(8'h02, a);
    for (int i = 0; i < n; i++) clock_byte(d[31-8*i -: 8]);
    stop();
  endtask

  task automatic rd(input int sel, input logic [23:0] a, input int n, input logic [31:0] d);
    start(sel);
    hdr(8'h03, a);
    if (sel == 0) begin
      repeat (4) clock_byte(8'h00);
      check("oe0_after_dummy", {31'h0, oe0}, 32'h0);
    end else begin
      check("oe1_after_addr", {31'h0, oe1}, 32'h0);
    end
    for (int i = 0; i < n; i++) begin
      if (sel == 0) q0.push_back(d[31-8*i -: 8]);
      else          q1.push_back(d[31-8*i -: 8]);
      clock_byte(8'h00);
    end
    stop();
  endtask

  initial begin
    tick(4);
    reset = 1'b0;
    tick(2);
    check("reset_dout", {24'h0, dout0}, 32'h0);
    check("reset_oe", {31'h0, oe0}, 32'h0);
    check("reset_active", {31'h0, act0}, 32'h0);
    check("reset_err", {31'h0, err0}, 32'h0);

    // Write then read with 4 dummy cycles
    wr(0, 24'h001234, 4, 32'hAA5501FE);
    rd(0, 24'h001234, 4, 32'hAA5501FE);

    // Zero-latency instance
    wr(1, 24'h001234, 4, 32'hAA5501FE);
    rd(1, 24'h001235, 2, 32'h55010000);

    // Wrap past the top and ignored upper address bits
    wr(0, 24'h00FFFF, 2, 32'h11220000);
    rd(0, 24'h00FFFF, 2, 32'h11220000);
    rd(0, 24'h000000, 1, 32'h22000000);
    wr(0, 24'h7F0010, 1, 32'h5A000000);
    rd(0, 24'h000010, 1, 32'h5A000000);

    // Unknown command
    start(0);
    clock_byte(8'h9F);
    clock_byte(8'h12);
    clock_byte(8'h34);
    clock_byte(8'h56);
    check("ignore_oe", {31'h0, oe0}, 32'h0);
    check("ignore_active", {31'h0, act0}, 32'h1);
    stop();
    check("cmd_error_cycles", err_cnt0, 32'd1);
    rd(0, 24'h001234, 4, 32'hAA5501FE);

    // Deselect mid-write keeps committed bytes only
    wr(0, 24'h002000, 4, 32'hEEEEEEEE);
    start(0);
    hdr(8'h02, 24'h002000);
    clock_byte(8'h01);
    clock_byte(8'h02);
    cs0 = 1'b1;
    tick(2);
    check("deselect_active", {31'h0, act0}, 32'h0);
    tick(2);
    rd(0, 24'h002000, 4, 32'h0102EEEE);

    // Reset during RDATA
    start(0);
    hdr(8'h03, 24'h001234);
    repeat (4) clock_byte(8'h00);
    sclk = 1'b0;
    tick(4);
    check("rdata_oe", {31'h0, oe0}, 32'h1);
    check("rdata_first", {24'h0, dout0}, 32'hAA);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midreset_oe", {31'h0, oe0}, 32'h0);
    check("midreset_dout", {24'h0, dout0}, 32'h0);
    check("midreset_active", {31'h0, act0}, 32'h0);
    @(negedge clk);
    cs0 = 1'b1;
    tick(2);
    reset = 1'b0;
    sclk = 1'b1;
    tick(4);
    rd(0, 24'h001234, 4, 32'hAA5501FE);

    check("q0_drained", q0.size(), 32'd0);
    check("q1_drained", q1.size(), 32'd0);
    check("cmd_error_lat0", err_cnt1, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
